// File: rtl/mem_resp.sv
// mem_resp: wait-stated data memory responder with a combinational pipeline stall.
// Define MEM_ERR_CHK_EN to reject misaligned or out-of-range accesses through addr_err.
module mem_resp #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM_Ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_valid,
    output logic        addr_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    waitCnt_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          write_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic          memValid_q;
    logic          addrErr_q;

    logic [AW-1:0] idx_d;
    logic          err_d;

    logic [31:0]   mem [DEPTH];

    assign idx_d = addr[AW+1:2];

`ifdef MEM_ERR_CHK_EN
    assign err_d = (addr[1:0] != 2'b00) || (|addr[31:AW+2]);
`else
    // Without checking, the byte offset and high address bits simply alias.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addr[31:AW+2], addr[1:0]};
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            waitCnt_q  <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            memValid_q <= 1'b0;
            addrErr_q  <= 1'b0;
        end else begin
            memValid_q <= 1'b0;
            addrErr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (MEM_Ctrl[1]) begin
                        idx_q     <= idx_d;
                        wdata_q   <= wdata;
                        write_q   <= MEM_Ctrl[0];
                        err_q     <= err_d;
                        waitCnt_q <= 4'(WAIT);
                        if (WAIT == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT_ST;
                        end
                    end
                end
                WAIT_ST: begin
                    waitCnt_q <= waitCnt_q - 4'd1;
                    if (waitCnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Memory write for this edge happens in the array block below.
                    if (!err_q && !write_q) begin
                        rdata_q <= mem[idx_q];
                    end
                    memValid_q <= !err_q;
                    addrErr_q  <= err_q;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The array is deliberately not reset; an async reset pulls state_q out of RESP, aborting the write.
    always_ff @(posedge clk) begin
        if (state_q == RESP && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = ((state_q == IDLE) && MEM_Ctrl[1]) || (state_q == WAIT_ST);
        end
    end

    assign rdata     = rdata_q;
    assign mem_valid = memValid_q;
    assign addr_err  = addrErr_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed self-checking bench for mem_resp: one WAIT=2 instance and one WAIT=0 instance.
// Expectations for misaligned/out-of-range accesses follow MEM_ERR_CHK_EN.
module tb_mem_resp;
    localparam int WAIT_U0 = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  MEM_Ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_valid;
    logic        addr_err;

    logic [1:0]  ctrl1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        stall1;
    logic        valid1;
    logic        err1;

    int checks = 0;
    int errors = 0;

    mem_resp #(.DEPTH(64), .WAIT(WAIT_U0)) u0 (
        .clk       (clk),
        .rst       (rst),
        .MEM_Ctrl  (MEM_Ctrl),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_valid (mem_valid),
        .addr_err  (addr_err)
    );

    mem_resp #(.DEPTH(64), .WAIT(0)) u1 (
        .clk       (clk),
        .rst       (rst),
        .MEM_Ctrl  (ctrl1),
        .addr      (addr1),
        .wdata     (wdata1),
        .rdata     (rdata1),
        .stall     (stall1),
        .mem_valid (valid1),
        .addr_err  (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
        MEM_Ctrl = c;
        addr     = a;
        wdata    = w;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Full access on u0; command is held until the edge that ends RESP, like a frozen pipeline.
    task automatic runAccess(input string tag, input logic [1:0] c, input logic [31:0] a,
                             input logic [31:0] w, input logic expErr, input logic [31:0] expRdata);
        @(negedge clk);
        applyStimulus(c, a, w);
        #1;
        checkOutput({tag, "_stall_req"}, 32'(stall), 32'd1);
        for (int i = 0; i < WAIT_U0; i++) begin
            @(negedge clk);
            #1;
            checkOutput({tag, "_stall_wait"}, 32'(stall), 32'd1);
            checkOutput({tag, "_valid_wait"}, 32'(mem_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        checkOutput({tag, "_stall_resp"}, 32'(stall), 32'd0);
        checkOutput({tag, "_valid_resp"}, 32'(mem_valid), 32'd0);
        @(negedge clk);
        applyStimulus(2'b00, 32'd0, 32'd0);
        #1;
        checkOutput({tag, "_valid_pulse"}, 32'(mem_valid), 32'(!expErr));
        checkOutput({tag, "_err_pulse"}, 32'(addr_err), 32'(expErr));
        checkOutput({tag, "_rdata"}, rdata, expRdata);
        checkOutput({tag, "_stall_after"}, 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_valid_end"}, 32'(mem_valid), 32'd0);
        checkOutput({tag, "_err_end"}, 32'(addr_err), 32'd0);
    endtask

    logic isChk;
    logic [31:0] word0After;

    initial begin
`ifdef MEM_ERR_CHK_EN
        isChk = 1'b1;
`else
        isChk = 1'b0;
`endif
        rst = 1'b1;
        applyStimulus(2'b10, 32'h10, 32'd0);
        ctrl1  = 2'b10;
        addr1  = 32'd0;
        wdata1 = 32'd0;
        #2;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_err", 32'(addr_err), 32'd0);
        checkOutput("rst_stall1", 32'(stall1), 32'd0);
        checkOutput("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        applyStimulus(2'b00, 32'd0, 32'd0);
        ctrl1 = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_stall", 32'(stall), 32'd0);

        // Write then read back at 0x10.
        runAccess("wr10", 2'b11, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        runAccess("rd10", 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        runAccess("wr00", 2'b11, 32'h00, 32'h11111111, 1'b0, 32'hDEADBEEF);
        runAccess("wr08", 2'b11, 32'h08, 32'h5A5A5A5A, 1'b0, 32'hDEADBEEF);

        // Command 01 (write without enable) is ignored.
        @(negedge clk);
        applyStimulus(2'b01, 32'h10, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("ign01_stall", 32'(stall), 32'd0);
            checkOutput("ign01_valid", 32'(mem_valid), 32'd0);
            checkOutput("ign01_err", 32'(addr_err), 32'd0);
            @(negedge clk);
        end
        applyStimulus(2'b00, 32'd0, 32'd0);
        runAccess("rd10_after01", 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Out-of-range read: error with checking, aliases to word 0 without.
        runAccess("rd100", 2'b10, 32'h100, 32'h0, isChk, isChk ? 32'hDEADBEEF : 32'h11111111);

        // Misaligned write of 0x1234 to 0x102: aliases to word 0 without checking.
        word0After = isChk ? 32'h11111111 : 32'h00001234;
        runAccess("wr102", 2'b11, 32'h102, 32'h1234, isChk, isChk ? 32'hDEADBEEF : 32'h11111111);
        runAccess("rd00", 2'b10, 32'h00, 32'h0, 1'b0, word0After);

        // Reset during the second wait cycle of a write aborts it.
        @(negedge clk);
        applyStimulus(2'b11, 32'h08, 32'hA5A5A5A5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_stall_in_rst", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort_rdata_rst", rdata, 32'd0);
        checkOutput("abort_valid_rst", 32'(mem_valid), 32'd0);
        @(negedge clk);
        applyStimulus(2'b00, 32'd0, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("abort_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("abort_no_valid", 32'(mem_valid), 32'd0);
        checkOutput("abort_no_err", 32'(addr_err), 32'd0);
        runAccess("rd08", 2'b10, 32'h08, 32'h0, 1'b0, 32'h5A5A5A5A);

        // WAIT=0 instance: one stall cycle, RESP next, pulse after that.
        @(negedge clk);
        ctrl1 = 2'b11; addr1 = 32'h04; wdata1 = 32'hCAFEF00D;
        #1;
        checkOutput("w0_wr_stall_req", 32'(stall1), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("w0_wr_stall_resp", 32'(stall1), 32'd0);
        checkOutput("w0_wr_valid_resp", 32'(valid1), 32'd0);
        @(negedge clk);
        ctrl1 = 2'b00;
        #1;
        checkOutput("w0_wr_valid", 32'(valid1), 32'd1);
        @(negedge clk);
        ctrl1 = 2'b10; addr1 = 32'h04; wdata1 = 32'd0;
        #1;
        checkOutput("w0_rd_stall_req", 32'(stall1), 32'd1);
        checkOutput("w0_rd_valid_idle", 32'(valid1), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("w0_rd_stall_resp", 32'(stall1), 32'd0);
        checkOutput("w0_rd_valid_resp", 32'(valid1), 32'd0);
        @(negedge clk);
        ctrl1 = 2'b00;
        #1;
        checkOutput("w0_rd_valid", 32'(valid1), 32'd1);
        checkOutput("w0_rd_err", 32'(err1), 32'd0);
        checkOutput("w0_rd_rdata", rdata1, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        checkOutput("w0_rd_valid_end", 32'(valid1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
